// File: rtl/kbd_fifo_if.sv
// Bus bundle for the keyboard input stage: the CPU-side register access
// signals, the two character-source strobes and the read/status outputs.
interface kbd_fifo_if;
  logic       enable;
  logic       cs;
  logic       address;
  logic       w_en;
  logic       ps2_stb;
  logic [7:0] ps2_data;
  logic       uart_stb;
  logic [7:0] uart_data;
  logic [7:0] dout;
  logic       rx_empty;
  logic       rx_full;

  // Driver side: the CPU bus and the character sources
  modport master (
    output enable, cs, address, w_en,
    output ps2_stb, ps2_data, uart_stb, uart_data,
    input  dout, rx_empty, rx_full
  );

  // The keyboard FIFO itself
  modport slave (
    input  enable, cs, address, w_en,
    input  ps2_stb, ps2_data, uart_stb, uart_data,
    output dout, rx_empty, rx_full
  );
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard input stage: merges PS/2 and UART characters into one FIFO and
// presents Apple-1 style KBD (data) and KBDCR (status) registers to the CPU.
// A UART byte that loses arbitration is parked in a one-entry holding register;
// any character that cannot be stored sets a sticky overflow flag.
module kbd_fifo #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter bit UPCASE = 1'b1
) (
  input logic   clk25,
  input logic   rst_n,
  kbd_fifo_if.slave bus
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   CNT_ONE    = 1;

  // Only seven bits are kept: the CPU always sees bit 7 forced high on KBD.
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [6:0]    last;
  logic [7:0]    pend;
  logic          pend_v;
  logic          ovf;

  logic       empty;
  logic       full;
  logic [6:0] head;
  logic       pop;
  logic       status_rd;
  logic       push_req;
  logic [7:0] push_data;
  logic       push_ok;
  logic       push_drop;
  logic       pend_load;
  logic       pend_clear;
  logic       uart_drop;

  function automatic logic [6:0] upcase(input logic [7:0] c);
    if (UPCASE && (c >= 8'h61) && (c <= 8'h7A))
      return c[6:0] - 7'h20;
    return c[6:0];
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign head      = mem[rd_ptr];
  assign pop       = bus.cs & bus.enable & ~bus.w_en & ~bus.address & ~empty;
  assign status_rd = bus.cs & bus.enable & ~bus.w_en & bus.address;

  assign bus.rx_empty = empty;
  assign bus.rx_full  = full;

  // Single write port arbitration: PS/2 first, then a parked UART byte, then a fresh UART byte
  always_comb begin
    push_req   = 1'b0;
    push_data  = bus.ps2_data;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    uart_drop  = 1'b0;
    if (bus.ps2_stb) begin
      push_req  = 1'b1;
      push_data = bus.ps2_data;
    end else if (pend_v) begin
      push_req   = 1'b1;
      push_data  = pend;
      pend_clear = 1'b1;
    end else if (bus.uart_stb) begin
      push_req  = 1'b1;
      push_data = bus.uart_data;
    end
    if (bus.uart_stb && (bus.ps2_stb || pend_v)) begin
      if (pend_v)
        uart_drop = 1'b1;
      else
        pend_load = 1'b1;
    end
  end

  // A simultaneous pop frees a slot, so a push on a full FIFO still lands then
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & full & ~pop;

  // Register read mux: KBD shows the head (or the last popped char when empty)
  always_comb begin
    if (bus.address)
      bus.dout = {~empty, ovf, 6'b0};
    else
      bus.dout = {1'b1, empty ? last : head};
  end

  // Pointers, occupancy, holding register, last-read char and overflow flag
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        last   <= head;
      end
      if (push_ok && !pop)
        count <= count + CNT_ONE;
      else if (!push_ok && pop)
        count <= count - CNT_ONE;
      if (pend_load) begin
        pend   <= bus.uart_data;
        pend_v <= 1'b1;
      end else if (pend_clear) begin
        pend_v <= 1'b0;
      end
      if (push_drop || uart_drop)
        ovf <= 1'b1;
      else if (status_rd)
        ovf <= 1'b0;
    end
  end

  // Character storage, case-folded on the way in
  always_ff @(posedge clk25) begin
    if (push_ok)
      mem[wr_ptr] <= upcase(push_data);
  end

endmodule
